// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int CNT_W  = 16;
    localparam int BCNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req scanning ptr+1, ptr+2, ... and wrapping
// back to ptr itself, so ptr holds the lowest priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] cand;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; otherwise synthesis infers a latch.
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
        for (int k = NREQ; k >= 1; k--) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the asynchronous FIFO write port among NREQ producers.
// Define FIFO_ARB_CNT_EN to add per-requester saturating beat counters (cnt_sel/cnt_out/cnt_clr).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              ivalid,
    output logic [W-1:0]      din,
    input  logic              iready,
`ifdef FIFO_ARB_CNT_EN
    input  logic [IDW-1:0]    cnt_sel,
    output logic [CNT_W-1:0]  cnt_out,
    input  logic              cnt_clr,
`endif
    output logic [IDW-1:0]    gnt_id,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic [IDW-1:0]    gnt_q, gnt_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [BCNT_W-1:0] beat_q, beat_d;

    logic              sel_valid;
    logic [W-1:0]      sel_data;
    logic              beat;
    logic              rel;
    logic              pick_found;
    logic [IDW-1:0]    pick_idx;

    // rr_q equals gnt_q throughout GRANT, so one picker serves both IDLE and release.
    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy   = (state_q == ARB_GRANT);
    assign gnt_id = gnt_q;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == IDW'(i)) begin
                sel_valid    = req_valid[i];
                sel_data     = req_data[i*W +: W];
                req_ready[i] = busy & iready;
            end
        end
        ivalid = busy & sel_valid;
        din    = sel_data;
        beat   = ivalid & iready;
        rel    = (beat && (beat_q == BCNT_W'(MAX_BURST - 1))) || !sel_valid;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_idx;
                    rr_d    = pick_idx;
                    beat_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (rel) begin
                    beat_d = '0;
                    if (pick_found) begin
                        gnt_d = pick_idx;
                        rr_d  = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (beat) begin
                    beat_d = beat_q + BCNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples values from before the edge regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            rr_q    <= IDW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

`ifdef FIFO_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q [NREQ];
    logic [CNT_W-1:0] cnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (beat && (gnt_q == IDW'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: this counter array is reset because software reads it as statistics;
    // storage that only ever holds data written before it is read needs no reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a behavioural model predicts each FIFO write beat,
// a monitor pops and compares whenever the DUT writes. FIFO_ARB_CNT_EN adds counter tests.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              ivalid;
    logic [W-1:0]      din;
    logic              iready = 1'b0;
    logic [IDW-1:0]    gnt_id;
    logic              busy;
`ifdef FIFO_ARB_CNT_EN
    logic [IDW-1:0]    cnt_sel = '0;
    logic [15:0]       cnt_out;
    logic              cnt_clr = 1'b0;
`endif

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .W         (W),
        .MAX_BURST (MAX_BURST),
        .IDW       (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ivalid    (ivalid),
        .din       (din),
        .iready    (iready),
`ifdef FIFO_ARB_CNT_EN
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out),
        .cnt_clr   (cnt_clr),
`endif
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Model state: who owns the port, how many beats it has sent, who was granted last.
    bit   m_busy;
    int   m_owner;
    int   m_last;
    int   m_beats;
    int   m_cnt[NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_beats = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, check cycle-level outputs, predict beat, advance model.
    task automatic step(input logic [NREQ-1:0] v, input logic rdy);
        logic            exp_iv;
        logic [NREQ-1:0] exp_rr;
        bit              hit;
        int              nxt;
        exp_t            e;
        @(negedge clk);
        #1;
        req_valid = v;
        iready    = rdy;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = W'($urandom);
        #1;
        exp_iv = m_busy && v[m_owner];
        exp_rr = '0;
        if (m_busy && rdy) exp_rr[m_owner] = 1'b1;
        check("busy", 32'(busy), 32'(m_busy));
        check("ivalid", 32'(ivalid), 32'(exp_iv));
        check("req_ready", 32'(req_ready), 32'(exp_rr));
        if (m_busy) check("gnt_id", 32'(gnt_id), m_owner);
        hit = exp_iv && rdy;
        if (hit) begin
            e.id   = m_owner;
            e.data = req_data[m_owner*W +: W];
            exp_q.push_back(e);
            m_beats++;
            if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
        end
`ifdef FIFO_ARB_CNT_EN
        if (cnt_clr) begin
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end
`endif
        if (!m_busy || !v[m_owner] || m_beats == MAX_BURST) begin
            nxt = pick(m_last, v);
            if (nxt >= 0) begin
                m_busy  = 1'b1;
                m_owner = nxt;
                m_last  = nxt;
                m_beats = 0;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    // Asserts reset mid-cycle with the current inputs still applied.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_ivalid", 32'(ivalid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_gnt_id", 32'(gnt_id), 0);
        model_reset();
        req_valid = '0;
        iready    = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: every FIFO write beat must match the oldest predicted beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst && ivalid && iready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: gnt_id %0d din 0x%0h, expected no beat at %0t",
                             gnt_id, din, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_gnt", 32'(gnt_id), e.id);
                    check("beat_din", 32'(din), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] v;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_ivalid", 32'(ivalid), 0);
        check("reset_gnt_id", 32'(gnt_id), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        rst = 1'b1;

        // Single requester: grant cycle, 6 beats with a bubble-free re-grant, then drop.
        repeat (7) step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("single_busy_fell", 32'(busy), 0);

        // All four valid: grant order 0,1,2,3,0 with 16+ back-to-back beats.
        do_reset();
        repeat (19) step(4'b1111, 1'b1);
        check("all_wrap_gnt", 32'(gnt_id), 0);

        // Backpressure mid-burst on requester 2.
        do_reset();
        repeat (3) step(4'b0100, 1'b1);
        repeat (3) step(4'b0100, 1'b0);
        check("stall_gnt", 32'(gnt_id), 2);
        repeat (3) step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);

        // Requester 1 drops valid after 2 beats while requester 3 waits.
        do_reset();
        repeat (3) step(4'b1010, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        check("drop_next_gnt", 32'(gnt_id), 3);
        repeat (4) step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);

        // Reset during beat 2 of requester 1, then requester 0 wins first.
        do_reset();
        repeat (3) step(4'b0010, 1'b1);
        do_reset();
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        check("post_reset_first_gnt", 32'(gnt_id), 0);

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) v = '0;
            step(v, ($urandom_range(3) != 0));
        end

`ifdef FIFO_ARB_CNT_EN
        do_reset();
        cnt_sel = 2'd3;
        repeat (70002) step(4'b1000, 1'b1);
        check("cnt_saturate", 32'(cnt_out), 32'hFFFF);
        cnt_sel = 2'd0;
        #1;
        check("cnt_other_zero", 32'(cnt_out), m_cnt[0]);
        cnt_clr = 1'b1;
        step(4'b1000, 1'b1);
        cnt_clr = 1'b0;
        step(4'b0000, 1'b1);
        for (int i = 0; i < NREQ; i++) begin
            cnt_sel = IDW'(i);
            #1;
            check("cnt_cleared", 32'(cnt_out), m_cnt[i]);
        end
`endif

        repeat (3) step(4'b0000, 1'b1);
        #5;
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the 8-bit input port of the asynchronous FIFO (ivalid/iready/din) among NREQ requesters in the write clock domain. It grants one requester at a time for a bounded burst. It hands off to the next requester without a bubble and forwards the FIFO's backpressure to the granted requester only. It sits between the producer blocks and the FIFO write port.

## Interface
- NREQ, 4, number of requesters; legal range 2..16.
- W, 8, data width; must match the FIFO data width.
- MAX_BURST, 4, maximum beats per grant; legal range 1..255.
- IDW, $clog2(NREQ), derived; grant index width.

- clk  in  1  write-domain clock, the same clock as the FIFO write side.
- rst  in  1  reset, asynchronous and active-low.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*W  per-requester data; requester i occupies bits [i*W +: W].
- req_ready  out  NREQ  per-requester accept; at most one bit is high.
- ivalid  out  1  to the FIFO write port.
- din  out  W  to the FIFO write port.
- iready  in  1  from the FIFO; low means full.
- gnt_id  out  IDW  currently granted requester.
- busy  out  1  high while in GRANT.

## Operation
- Two states, IDLE and GRANT, plus these registers:
  - gnt_id.
  - rr_ptr, the last requester granted.
  - beat_cnt, 8 bits.
- **Pick function.** Return the first i with req_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, …, wrapping modulo NREQ, and ending at rr_ptr itself (so rr_ptr has lowest priority). Return "none" if no bit is set.
- **IDLE.**
  - Drive ivalid=0 and req_ready=0.
  - If pick returns i, go to GRANT with gnt_id=i, rr_ptr=i, beat_cnt=0.
- **GRANT (g = gnt_id).**
  - ivalid = req_valid[g].
  - din = req_data[g].
  - req_ready[g] = iready; all other req_ready bits are 0.
  - A beat is a clock edge where ivalid && iready.
- **Release conditions** (evaluated each GRANT cycle):
  - (a) a beat occurs with beat_cnt == MAX_BURST-1;
  - (b) req_valid[g] == 0.
- **On release:**
  - Evaluate pick in the same cycle using the current req_valid, with rr_ptr=g.
  - If pick returns i, stay in GRANT with gnt_id=i, rr_ptr=i, beat_cnt=0.
  - Otherwise go to IDLE.
- **Without release:** a beat increments beat_cnt. With iready=0 the grant and beat_cnt hold indefinitely.
- **Data path and widths.**
  - The data path is combinational from req_data to din; there is no storage in the arbiter.
  - rr_ptr and gnt_id increment modulo NREQ. This also holds for non-power-of-2 NREQ: from NREQ-1 the next index is 0.
- **Reset.** rst low clears immediately and regardless of any in-flight burst:
  - state=IDLE, gnt_id=0, rr_ptr=NREQ-1 (requester 0 wins first), beat_cnt=0.
  - ivalid=0, req_ready=0, busy=0, all counters 0.
  - A partially sent burst is simply abandoned.

## Timing
- Arbitration latency from IDLE: req_valid rises before edge t; the grant registers at edge t; ivalid is high during cycle t+1. The first beat is possible at edge t+1.
- Handoff: a release at edge t gives the new grant effective in cycle t+1. There is zero bubble cycles between bursts.
- Single active requester: the same requester is re-granted immediately after each MAX_BURST beats. This causes no throughput loss.
- Outputs ivalid, din and req_ready are combinational from registered state plus req_valid, req_data and iready. There is no combinational path from iready to ivalid.

## Configuration
- FIFO_ARB_CNT_EN defined: the block adds per-requester 16-bit saturating beat counters and the following ports:
  - cnt_sel in IDW.
  - cnt_out out 16, driven combinationally as cnt[cnt_sel].
  - cnt_clr in 1, a synchronous clear of all counters; clear takes precedence over increment.
- Counter behaviour: a counter increments on each beat of its requester and sticks at 16'hFFFF.
- FIFO_ARB_CNT_EN undefined: no counters and no extra ports.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_GRANT);
  - the counter width constant CNT_W=16;
  - the burst counter width constant BCNT_W=8.
- Sub-module rr_pick (combinational): inputs req[NREQ] and ptr[IDW]; outputs found and idx[IDW]. It is instantiated once in fifo_wr_arbiter.

## Test plan
- **Single requester, 6 beats:** only req 0 valid, MAX_BURST=4, iready=1.
  - Beats 0–3 occur in cycles 1–4.
  - req 0 is re-granted with no bubble; beats 4–5 occur in cycles 5–6.
  - busy falls after req_valid drops.
- **All four valid continuously:** the grant order is 0,1,2,3,0. Each grant is 4 beats, for 16 consecutive beats with no idle cycle.
- **iready=0 for 3 cycles mid-burst** (after beat 1 of req 2):
  - req_ready is all 0 and gnt_id stays 2.
  - beat_cnt holds at 2; the remaining 2 beats complete after iready returns.
- **Requester drops valid:** req 1 drops req_valid after 2 beats while req 3 is valid.
  - Next cycle gnt_id=3, and req 3 gets a full 4 beats.
- **Reset mid-burst:** rst low during beat 2 of req 1.
  - ivalid=0, busy=0 and gnt_id=0 immediately.
  - After release, with all valid, req 0 is granted first.
- **With FIFO_ARB_CNT_EN:**
  - Drive 70000 beats from req 3: cnt_out with cnt_sel=3 reads 16'hFFFF.
  - Pulse cnt_clr: all counters read 0 the next cycle.
